wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//  Write-back end of the MEM/WB pipeline register. Consumes MEM/WB outputs and
//  selects the write-back value (ALU result, load data or PC+4). Writes it into
//  the integer register file, which serves the two decode-stage read ports
//  with write-through bypass. Also keeps the retired-instruction counter
//  (instret) for the RV32I core.
// PARAMETERS
//  XLEN   32  datapath / register width
//  NREG   32  number of architectural registers (x0..x31); index width = $clog2(NREG)
//  CNT_W  64  width of retired-instruction counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset: asynchronous, active-high
//  pc4        in   XLEN   PC+4 from MEM/WB
//  jump       in   1      JAL/JALR in WB; selects pc4
//  c          in   XLEN   ALU result from MEM/WB
//  d          in   XLEN   load data from MEM/WB (already aligned/extended)
//  rd         in   5      destination register index
//  opcode     in   7      instruction opcode in WB
//  wr_reg_n   in   1      active-low register write enable
//  retire     in   1      WB slot holds a real instruction (0 = bubble/flush)
//  rs1, rs2   in   5      decode-stage source indices
//  rs1_data   out  XLEN   read data for rs1
//  rs2_data   out  XLEN   read data for rs2
//  wb_data    out  XLEN   selected write-back value (to forwarding mux)
//  wb_we      out  1      effective write strobe this cycle
//  instret    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Write-back select (combinational), priority order:
//   - jump=1 -> pc4
//   - else opcode==7'b0000011 (LOAD) -> d
//   - else -> c
//  Write enable: wb_we = !wr_reg_n && retire && (rd!=0) && !rst.
//  Register file: regs[1..NREG-1]; x0 reads 0 and is never written.
//   - On posedge clk with wb_we=1: regs[rd] <= wb_data. Latency 1 cycle.
//  Read ports (combinational, zero latency):
//   - rsN==0 -> 0.
//   - else wb_we && rd==rsN -> wb_data (same-cycle bypass; new value visible in ID).
//   - else regs[rsN].
//   - rs1==rs2==rd: both ports bypass.
//  instret: increments by 1 on posedge clk when retire=1 && !rst.
//   - Increments regardless of wr_reg_n (stores and branches retire).
//   - Wraps modulo 2^CNT_W, all-ones -> 0, no flag.
//  Reset (rst=1, asynchronous, effective immediately, no clock needed):
//   - All regs cleared to 0; instret <= 0.
//   - wb_we forced 0; rs1_data/rs2_data read 0 (bypass suppressed).
//   - wb_data still follows the select logic (don't-care while rst=1).
//   - rst asserted mid-stream discards any write in that cycle.
//   - First write possible at the first posedge after rst deasserts.
//  X-safety: the MEM/WB reset drives x on c/d/pc4/rd/opcode with wr_reg_n=1.
//   - With wr_reg_n=1 or retire=0: no register changes, no bypass, regardless
//     of x on other inputs.
// TESTING
//  1 Reset: rst=1 async mid-cycle -> every rsN reads 0, instret=0, wb_we=0
//    immediately.
//  2 ALU write: opcode=0110011, c=0x1234_5678, rd=5, wr_reg_n=0, retire=1
//    -> rs1=5 reads 0x1234_5678 same cycle (bypass) and after the edge (stored).
//  3 Select:
//    - LOAD opcode=0000011, d=0xDEAD_BEEF, c=0x1 -> wb_data=0xDEAD_BEEF.
//    - jump=1, pc4=0x104 -> wb_data=0x104 and rd holds 0x104 next cycle.
//  4 x0 guard: rd=0, wr_reg_n=0, c=0xFFFF_FFFF -> wb_we=0, rs1=0 reads 0
//    before and after the edge.
//  5 Bubble/store: wr_reg_n=1 with rd=7 and c=x; then retire=0 with wr_reg_n=0
//    -> x7 unchanged, no bypass. instret +1 for the store only.
//  6 Counter:
//    - 10 retire cycles -> instret=10.
//    - Preload via force to all-ones, one retire -> instret=0.
//    - rst mid-run -> instret=0 at once.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register, the write-back stage and decode.
// The master side drives the MEM/WB and decode requests; the slave side is the register file.
interface wb_regfile_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
);
  localparam int unsigned IW = $clog2(NREG);

  logic [XLEN-1:0]  pc4;
  logic             jump;
  logic [XLEN-1:0]  c;
  logic [XLEN-1:0]  d;
  logic [IW-1:0]    rd;
  logic [6:0]       opcode;
  logic             wr_reg_n;
  logic             retire;
  logic [IW-1:0]    rs1;
  logic [IW-1:0]    rs2;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  wb_data;
  logic             wb_we;
  logic [CNT_W-1:0] instret;

  modport master (
    output pc4, jump, c, d, rd, opcode, wr_reg_n, retire, rs1, rs2,
    input  rs1_data, rs2_data, wb_data, wb_we, instret
  );

  modport slave (
    input  pc4, jump, c, d, rd, opcode, wr_reg_n, retire, rs1, rs2,
    output rs1_data, rs2_data, wb_data, wb_we, instret
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, updates the integer register file
// (two bypassed read ports for decode) and counts retired instructions.
module wb_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned CNT_W = 64
) (
  input logic         clk,
  input logic         rst,
  wb_regfile_if.slave bus
);
  localparam int unsigned IW      = $clog2(NREG);
  localparam logic [6:0]  OP_LOAD = 7'b0000011;

  logic [XLEN-1:0]  regs_q [NREG];
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  wb_data;
  logic             wb_we;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;

  always_comb begin
    wb_data = bus.c;
    if (bus.jump) begin
      wb_data = bus.pc4;
    end else if (bus.opcode == OP_LOAD) begin
      wb_data = bus.d;
    end
  end

  // wr_reg_n/retire gate first so x on rd from a reset MEM/WB stage cannot leak through
  assign wb_we = !bus.wr_reg_n && bus.retire && (bus.rd != '0) && !rst;

  always_comb begin
    rs1_data = '0;
    if (rst || bus.rs1 == '0) begin
      rs1_data = '0;
    end else if (wb_we && bus.rd == bus.rs1) begin
      rs1_data = wb_data;
    end else begin
      rs1_data = regs_q[bus.rs1];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rst || bus.rs2 == '0) begin
      rs2_data = '0;
    end else if (wb_we && bus.rd == bus.rs2) begin
      rs2_data = wb_data;
    end else begin
      rs2_data = regs_q[bus.rs2];
    end
  end

  // Entry 0 is cleared on reset and never written, so x0 always holds zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_we) begin
      regs_q[bus.rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_q <= '0;
    end else if (bus.retire) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign bus.wb_data  = wb_data;
  assign bus.wb_we    = wb_we;
  assign bus.rs1_data = rs1_data;
  assign bus.rs2_data = rs2_data;
  assign bus.instret  = instret_q;

  logic unused_idx;
  assign unused_idx = ^{IW{1'b0}};
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: select, write/bypass, x0 guard, bubbles, counter and reset.
module tb_wb_regfile;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 64;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  wb_regfile_if #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.jump     = 1'b0;
    bus.wr_reg_n = 1'b1;
    bus.retire   = 1'b0;
    bus.opcode   = 7'b0110011;
    bus.rd       = 5'd0;
    bus.c        = '0;
    bus.d        = '0;
    bus.pc4      = '0;
  endtask

  task automatic alu_write(input logic [4:0] rd, input logic [31:0] val);
    idle();
    bus.rd       = rd;
    bus.c        = val;
    bus.wr_reg_n = 1'b0;
    bus.retire   = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    idle();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("init_instret", bus.instret, 64'd0);
    check_eq("init_we", {63'd0, bus.wb_we}, 64'd0);

    // ALU write to x5: bypass, then stored
    alu_write(5'd5, 32'h1234_5678);
    bus.rs1 = 5'd5;
    #1;
    check_eq("alu_we", {63'd0, bus.wb_we}, 64'd1);
    check_eq("alu_bypass", {32'd0, bus.rs1_data}, 64'h1234_5678);
    check_eq("alu_rs2_x0", {32'd0, bus.rs2_data}, 64'd0);
    tick();
    idle();
    #1;
    check_eq("alu_stored", {32'd0, bus.rs1_data}, 64'h1234_5678);
    check_eq("alu_instret", bus.instret, 64'd1);

    // LOAD selects d
    idle();
    bus.opcode = 7'b0000011; bus.d = 32'hDEAD_BEEF; bus.c = 32'h1;
    bus.rd = 5'd6; bus.wr_reg_n = 1'b0; bus.retire = 1'b1; bus.rs2 = 5'd6;
    #1;
    check_eq("load_wbdata", {32'd0, bus.wb_data}, 64'hDEAD_BEEF);
    check_eq("load_bypass", {32'd0, bus.rs2_data}, 64'hDEAD_BEEF);
    tick();
    idle();
    #1;
    check_eq("load_stored", {32'd0, bus.rs2_data}, 64'hDEAD_BEEF);

    // JAL selects pc4 over a LOAD-looking opcode; rs1==rs2==rd both bypass
    idle();
    bus.jump = 1'b1; bus.pc4 = 32'h104; bus.opcode = 7'b0000011; bus.c = 32'h55;
    bus.d = 32'h77; bus.rd = 5'd1; bus.wr_reg_n = 1'b0; bus.retire = 1'b1;
    bus.rs1 = 5'd1; bus.rs2 = 5'd1;
    #1;
    check_eq("jump_wbdata", {32'd0, bus.wb_data}, 64'h104);
    check_eq("jump_byp_rs1", {32'd0, bus.rs1_data}, 64'h104);
    check_eq("jump_byp_rs2", {32'd0, bus.rs2_data}, 64'h104);
    tick();
    idle();
    #1;
    check_eq("jump_stored", {32'd0, bus.rs1_data}, 64'h104);
    check_eq("jump_instret", bus.instret, 64'd3);

    // x0 guard
    alu_write(5'd0, 32'hFFFF_FFFF);
    bus.rs1 = 5'd0;
    #1;
    check_eq("x0_we", {63'd0, bus.wb_we}, 64'd0);
    check_eq("x0_before", {32'd0, bus.rs1_data}, 64'd0);
    tick();
    idle();
    #1;
    check_eq("x0_after", {32'd0, bus.rs1_data}, 64'd0);

    // Store then bubble against x7
    alu_write(5'd7, 32'hA5A5_0007);
    tick();
    idle();
    bus.rd = 5'd7; bus.c = 'x; bus.wr_reg_n = 1'b1; bus.retire = 1'b1; bus.rs1 = 5'd7;
    #1;
    check_eq("store_we", {63'd0, bus.wb_we}, 64'd0);
    check_eq("store_nobyp", {32'd0, bus.rs1_data}, 64'hA5A5_0007);
    tick();
    idle();
    bus.rd = 5'd7; bus.c = 32'h0BAD; bus.wr_reg_n = 1'b0; bus.retire = 1'b0;
    #1;
    check_eq("bubble_we", {63'd0, bus.wb_we}, 64'd0);
    check_eq("bubble_nobyp", {32'd0, bus.rs1_data}, 64'hA5A5_0007);
    tick();
    idle();
    #1;
    check_eq("x7_kept", {32'd0, bus.rs1_data}, 64'hA5A5_0007);
    check_eq("store_instret", bus.instret, 64'd6);

    // Async reset mid-cycle with a write pending
    alu_write(5'd9, 32'h9999);
    bus.rs1 = 5'd5; bus.rs2 = 5'd9;
    #2 rst = 1'b1;
    #1;
    check_eq("rst_rs1", {32'd0, bus.rs1_data}, 64'd0);
    check_eq("rst_rs2_nobyp", {32'd0, bus.rs2_data}, 64'd0);
    check_eq("rst_instret", bus.instret, 64'd0);
    check_eq("rst_we", {63'd0, bus.wb_we}, 64'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_eq("rst_x5_clear", {32'd0, bus.rs1_data}, 64'd0);
    check_eq("rst_x9_dropped", {32'd0, bus.rs2_data}, 64'd0);
    bus.rs1 = 5'd6;
    #1;
    check_eq("rst_x6_clear", {32'd0, bus.rs1_data}, 64'd0);

    // First write right after reset release
    alu_write(5'd9, 32'h9999);
    tick();
    idle();
    #1;
    check_eq("post_rst_write", {32'd0, bus.rs2_data}, 64'h9999);

    // Counter: 10 retires (stores) from zero
    rst = 1'b1;
    #1 rst = 1'b0;
    idle();
    bus.retire = 1'b1;
    repeat (10) tick();
    idle();
    #1;
    check_eq("cnt_ten", bus.instret, 64'd10);

    // Wrap from all-ones
    force dut.instret_q = {CNT_W{1'b1}};
    #1;
    check_eq("cnt_forced", bus.instret, 64'hFFFF_FFFF_FFFF_FFFF);
    release dut.instret_q;
    bus.retire = 1'b1;
    tick();
    idle();
    #1;
    check_eq("cnt_wrap", bus.instret, 64'd0);

    // Reset mid-run clears counter immediately
    bus.retire = 1'b1;
    repeat (3) tick();
    check_eq("cnt_run", bus.instret, 64'd3);
    #2 rst = 1'b1;
    #1;
    check_eq("cnt_rst", bus.instret, 64'd0);
    tick();
    rst = 1'b0;
    idle();
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
